bottling_counters_n: RTL
========================

Name: bottling_counters_n

Overview:
- Next-generation pill/bottle counting core for the bottling line, with digit widths set by parameters.
- Counts pill pulses into per-bottle and total BCD counters, and stops filling while a full bottle is swapped out.
- Pulses that arrive during a swap are counted as spills.
- Sits between the pill-sensor pulse conditioner and the display/control FSM; adds start/abort control, latched settings, a bottle-swap handshake and error flags.

Parameters:
- TOTAL_DIGITS, 3, BCD digits of the total pill counter
- BOTTLE_DIGITS, 2, BCD digits of the bottle counter and bottle setting
- PILL_DIGITS, 2, BCD digits of the per-bottle pill counter and pill setting
- SPILL_DIGITS, 2, BCD digits of the spill counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a run
- abort  in  1  single-cycle request to stop the run
- pill_pulse  in  1  single-cycle pill-detected pulse, already synchronised to clk
- bottle_ready  in  1  level; high when an empty bottle is positioned under the chute
- bottle_setting  in  4*BOTTLE_DIGITS  target bottle count (BCD)
- pill_setting  in  4*PILL_DIGITS  pills per bottle (BCD)
- total  out  4*TOTAL_DIGITS  pills dispensed into bottles this run (BCD)
- bottle  out  4*BOTTLE_DIGITS  completed bottles (BCD)
- pill  out  4*PILL_DIGITS  pills in the current bottle (BCD)
- spill  out  4*SPILL_DIGITS  pills dropped during a swap (BCD, saturating)
- state  out  2  current FSM state
- busy  out  1  high in FILL or SWAP
- bottle_full  out  1  one-cycle pulse when a bottle completes
- finished  out  1  high in DONE
- setting_error  out  1  sticky; a setting contained a non-BCD digit
- total_wrap  out  1  sticky; total wrapped past all-9s

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - total, bottle, pill and spill are zero.
  - All flags are 0.
  - Latched settings are zero.
- States: IDLE=0, FILL=1, SWAP=2, DONE=3.
- abort has priority over all other inputs. In any state it moves the FSM to IDLE next cycle; counters hold their values for display.
- start accepted in IDLE or DONE:
  - Clears all counters, setting_error and total_wrap.
  - Latches bottle_setting and pill_setting.
  - A pill_pulse in the start cycle is ignored.
- Setting checks at start:
  - Any setting digit >9: stay in IDLE and set setting_error.
  - Else bottle_setting==0 or pill_setting==0: go to DONE.
  - Else: go to SWAP, which waits for the first bottle.
- start in FILL or SWAP is ignored.
- FILL, on pill_pulse:
  - pill and total each increment by 1.
  - When pill equals latched pill_setting-1, pill instead returns to 0, bottle increments, and bottle_full pulses in that same cycle.
  - The next state is then DONE if the new bottle value equals the latched bottle_setting, otherwise SWAP.
- SWAP:
  - A registered bottle_ready is required to be low for at least one cycle, then high (rising edge, one cycle of sampling latency); this edge moves the FSM to FILL.
  - The first SWAP after start accepts a bottle_ready that is already high.
  - pill_pulse in SWAP increments spill (saturating at all-9s), not total or pill. This includes a pulse in the same cycle as the ready edge.
- DONE: counters are frozen and finished=1; pill_pulse is ignored.
- BCD rules:
  - Each digit wraps 9→0 with carry.
  - total wraps from all-9s to 0 and sets total_wrap.
  - bottle cannot exceed its setting.
  - Settings are compared digit-wise after latching.
- All outputs are registered, except that busy, finished and state decode directly from the state register.

Decomposition:
- Package bottling_pkg holds:
  - state_t enum (IDLE/FILL/SWAP/DONE).
  - bcd_digit_t (logic[3:0]).
  - Function bcd_valid(vector, digits).
  - Constant BCD_MAX_DIGIT=9.
- Sub-module bcd_chain, one instance per counter. Parameters: DIGITS, SATURATE. Ports:
  - clk, reset, clear, en.
  - wrap_at (BCD modulus; all-9s means free-run).
  - q, carry_out, at_max.

Test Plan:
- pill_setting=03, bottle_setting=02; start, bottle_ready high, 6 pulses with a ready toggle after pulse 3 → bottle_full on pulses 3 and 6; final pill=00, bottle=02, total=006, finished=1.
- Same settings; 2 pulses during SWAP, then a ready edge together with a third pulse → spill=03, total unchanged, state=FILL next cycle.
- pill_setting=0x1A → setting_error=1, state stays IDLE; pill_setting=00 → immediate DONE with bottle=00.
- abort mid-FILL at pill=02 → IDLE, counters hold 02; later start → all counters 0.
- TOTAL_DIGITS=1, pill_setting=99, 10 pulses → total=0, total_wrap=1, pill=10.
- Assert reset during FILL mid-pulse → outputs immediately zero and state=IDLE with no clock edge.

Source files
------------

// File: rtl/bottling_pkg.sv
// Shared types and helpers for the bottling counter core.
//   state_t       : FSM encoding exported on the state output
//   bcd_digit_t   : one BCD nibble
//   BCD_MAX_DIGIT : largest legal BCD digit value
//   bcd_valid()   : checks that the low 'digits' nibbles of a vector are all 0..9
package bottling_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SWAP = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_MAX_DIGIT  = 9;
  localparam int BCD_MAX_DIGITS = 8;

  // Callers zero-extend their setting to the full 32-bit argument; only the
  // low 'digits' nibbles are inspected.
  function automatic logic bcd_valid(input logic [4*BCD_MAX_DIGITS-1:0] vec,
                                     input int digits);
    logic       ok;
    bcd_digit_t d;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      d = vec[4*i +: 4];
      if ((i < digits) && (d > bcd_digit_t'(BCD_MAX_DIGIT))) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bottling_counters_n_bcd_chain.sv
// Multi-digit BCD up-counter used for every counter of the bottling core.
//   clk, reset : clock, asynchronous active-high reset (clears q)
//   clear      : synchronous clear, wins over en
//   en         : count one step
//   wrap_at    : last value before returning to 0 (all-9s gives a free-running
//                decimal counter)
//   q          : registered BCD count
//   carry_out  : high in a cycle where en makes q wrap back to 0
//   at_max     : q is all-9s
// With SATURATE=1 the counter holds at all-9s instead of wrapping.
module bcd_chain
  import bottling_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic [4*DIGITS-1:0] wrap_at,
  output logic [4*DIGITS-1:0] q,
  output logic                carry_out,
  output logic                at_max
);

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [4*DIGITS-1:0] r_q;
  logic [4*DIGITS-1:0] w_inc;
  logic                w_carry;
  logic                w_hold;
  logic                w_hit;

  // Ripple decimal increment: each 9 becomes 0 and passes the carry on.
  always_comb begin
    w_inc   = r_q;
    w_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_q[4*i +: 4] >= bcd_digit_t'(BCD_MAX_DIGIT)) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
    end
  end

  assign at_max    = (r_q == ALL_NINES);
  assign w_hold    = SATURATE && at_max;
  assign w_hit     = (r_q == wrap_at);
  assign carry_out = en && !w_hold && w_hit;
  assign q         = r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (en && !w_hold) begin
      r_q <= w_hit ? '0 : w_inc;
    end
  end

endmodule

// File: rtl/bottling_counters_n.sv
// Pill/bottle counting core for the bottling line.
//   clk, reset     : clock, asynchronous active-high reset
//   start, abort   : single-cycle run control (abort wins over everything)
//   pill_pulse     : single-cycle pill detect, already synchronous to clk
//   bottle_ready   : level, empty bottle positioned under the chute
//   bottle_setting : target bottle count (BCD), latched at start
//   pill_setting   : pills per bottle (BCD), latched at start
//   total, bottle, pill, spill : registered BCD counters
//   state, busy, finished      : decoded straight from the state register
//   bottle_full    : one-cycle pulse when a bottle completes
//   setting_error  : sticky, a setting held a non-BCD digit at start
//   total_wrap     : sticky, total rolled over past all-9s
//
// Bottle-swap handshake: after a bottle completes the core sits in SWAP and
// waits for bottle_ready, sampled through one register, to be seen low and
// then high; that rising edge is the "new bottle in place" event that
// re-enters FILL. The first SWAP after start is pre-armed so an already
// present bottle is accepted. Pulses seen while in SWAP (including the cycle
// of the edge) are spills.
module bottling_counters_n
  import bottling_pkg::*;
#(
  parameter int TOTAL_DIGITS  = 3,
  parameter int BOTTLE_DIGITS = 2,
  parameter int PILL_DIGITS   = 2,
  parameter int SPILL_DIGITS  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       pill_pulse,
  input  logic                       bottle_ready,
  input  logic [4*BOTTLE_DIGITS-1:0] bottle_setting,
  input  logic [4*PILL_DIGITS-1:0]   pill_setting,
  output logic [4*TOTAL_DIGITS-1:0]  total,
  output logic [4*BOTTLE_DIGITS-1:0] bottle,
  output logic [4*PILL_DIGITS-1:0]   pill,
  output logic [4*SPILL_DIGITS-1:0]  spill,
  output logic [1:0]                 state,
  output logic                       busy,
  output logic                       bottle_full,
  output logic                       finished,
  output logic                       setting_error,
  output logic                       total_wrap
);

  localparam logic [4*TOTAL_DIGITS-1:0]  TOTAL_NINES  = {TOTAL_DIGITS{4'h9}};
  localparam logic [4*BOTTLE_DIGITS-1:0] BOTTLE_NINES = {BOTTLE_DIGITS{4'h9}};
  localparam logic [4*SPILL_DIGITS-1:0]  SPILL_NINES  = {SPILL_DIGITS{4'h9}};

  state_t                     r_state;
  state_t                     w_next;
  logic [4*BOTTLE_DIGITS-1:0] r_bottle_set;
  logic [4*PILL_DIGITS-1:0]   r_pill_set;
  logic                       r_ready_q;
  logic                       r_seen_low;
  logic                       r_bottle_full;
  logic                       r_setting_error;
  logic                       r_total_wrap;

  logic                       w_start_ok;
  logic                       w_set_ok;
  logic                       w_set_zero;
  logic                       w_fill_pulse;
  logic                       w_swap_pulse;
  logic                       w_ready_edge;
  logic                       w_pill_wrap;
  logic                       w_total_carry;
  logic                       w_last_bottle;
  logic [4*PILL_DIGITS-1:0]   w_pill_last;
  logic [4*BOTTLE_DIGITS-1:0] w_bottle_inc;
  logic                       w_borrow;
  logic                       w_carry;

  assign w_start_ok   = start && !abort && ((r_state == IDLE) || (r_state == DONE));
  assign w_set_ok     = bcd_valid(32'(bottle_setting), BOTTLE_DIGITS) &&
                        bcd_valid(32'(pill_setting), PILL_DIGITS);
  assign w_set_zero   = (bottle_setting == '0) || (pill_setting == '0);
  assign w_fill_pulse = pill_pulse && !abort && (r_state == FILL);
  assign w_swap_pulse = pill_pulse && !abort && (r_state == SWAP);
  assign w_ready_edge = r_seen_low && r_ready_q;

  // Pill counter wraps after setting-1: decimal decrement of the latched
  // setting. FILL is only reachable with a non-zero setting, so no underflow.
  always_comb begin
    w_pill_last = r_pill_set;
    w_borrow    = 1'b1;
    for (int i = 0; i < PILL_DIGITS; i++) begin
      if (w_borrow) begin
        if (r_pill_set[4*i +: 4] == 4'd0) begin
          w_pill_last[4*i +: 4] = 4'd9;
        end else begin
          w_pill_last[4*i +: 4] = r_pill_set[4*i +: 4] - 4'd1;
          w_borrow              = 1'b0;
        end
      end
    end
  end

  // Value the bottle counter takes when the current bottle completes.
  always_comb begin
    w_bottle_inc = bottle;
    w_carry      = 1'b1;
    for (int i = 0; i < BOTTLE_DIGITS; i++) begin
      if (w_carry) begin
        if (bottle[4*i +: 4] >= bcd_digit_t'(BCD_MAX_DIGIT)) begin
          w_bottle_inc[4*i +: 4] = 4'd0;
        end else begin
          w_bottle_inc[4*i +: 4] = bottle[4*i +: 4] + 4'd1;
          w_carry                = 1'b0;
        end
      end
    end
  end

  assign w_last_bottle = (w_bottle_inc == r_bottle_set);

  bcd_chain #(.DIGITS(PILL_DIGITS), .SATURATE(1'b0)) u_pill (
    .clk(clk), .reset(reset), .clear(w_start_ok), .en(w_fill_pulse),
    .wrap_at(w_pill_last), .q(pill), .carry_out(w_pill_wrap), .at_max()
  );

  bcd_chain #(.DIGITS(TOTAL_DIGITS), .SATURATE(1'b0)) u_total (
    .clk(clk), .reset(reset), .clear(w_start_ok), .en(w_fill_pulse),
    .wrap_at(TOTAL_NINES), .q(total), .carry_out(w_total_carry), .at_max()
  );

  bcd_chain #(.DIGITS(BOTTLE_DIGITS), .SATURATE(1'b0)) u_bottle (
    .clk(clk), .reset(reset), .clear(w_start_ok), .en(w_pill_wrap),
    .wrap_at(BOTTLE_NINES), .q(bottle), .carry_out(), .at_max()
  );

  bcd_chain #(.DIGITS(SPILL_DIGITS), .SATURATE(1'b1)) u_spill (
    .clk(clk), .reset(reset), .clear(w_start_ok), .en(w_swap_pulse),
    .wrap_at(SPILL_NINES), .q(spill), .carry_out(), .at_max()
  );

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            if (!w_set_ok)      w_next = IDLE;
            else if (w_set_zero) w_next = DONE;
            else                 w_next = SWAP;
          end
        end
        FILL: begin
          if (w_pill_wrap) w_next = w_last_bottle ? DONE : SWAP;
        end
        SWAP: begin
          if (w_ready_edge) w_next = FILL;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_bottle_set    <= '0;
      r_pill_set      <= '0;
      r_ready_q       <= 1'b0;
      r_seen_low      <= 1'b0;
      r_bottle_full   <= 1'b0;
      r_setting_error <= 1'b0;
      r_total_wrap    <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_ready_q     <= bottle_ready;
      r_bottle_full <= w_pill_wrap;

      if (w_start_ok) begin
        r_bottle_set    <= bottle_setting;
        r_pill_set      <= pill_setting;
        r_setting_error <= !w_set_ok;
      end

      if (w_start_ok)         r_total_wrap <= 1'b0;
      else if (w_total_carry) r_total_wrap <= 1'b1;

      // Pre-armed for the first bottle; disarmed when a bottle completes so
      // the swap needs a fresh low-then-high on bottle_ready.
      if (w_start_ok)                          r_seen_low <= 1'b1;
      else if (w_pill_wrap)                    r_seen_low <= 1'b0;
      else if ((r_state == SWAP) && !r_ready_q) r_seen_low <= 1'b1;
    end
  end

  assign state         = r_state;
  assign busy          = (r_state == FILL) || (r_state == SWAP);
  assign finished      = (r_state == DONE);
  assign bottle_full   = r_bottle_full;
  assign setting_error = r_setting_error;
  assign total_wrap    = r_total_wrap;

endmodule
